psum_accum_ctrl: RTL and testbench
==================================

# psum_accum_ctrl

Sequencer for the partial-sum/bias select mux in front of the accumulator adder. It counts input-channel passes and output positions for one layer and drives the 2-bit mux select: bias on the first pass, psum-buffer feedback (conv) or FC register feedback (FC) afterwards. It issues the buffer read, the delayed write-back and the final-result strobe. It sits between the layer controller (start/done) and the PE array / psum buffer.

## Interface
Parameters:
- CH_CNT_W, 8, width of the input-channel pass counter.
- POS_CNT_W, 12, width of the output-position counter and buffer address.
- ACC_LAT, 2, cycles from read issue to write-back (buffer read plus adder); legal range 1..4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches configuration; accepted only in IDLE.
- abort  in  1  synchronous cancel; has priority over every other input.
- mode  in  1  0 = conv (feedback from psum buffer), 1 = FC (feedback from fc_reg); sampled on start.
- num_pass  in  CH_CNT_W  number of input-channel passes; sampled on start.
- num_pos  in  POS_CNT_W  output positions per pass; sampled on start.
- pe_valid  in  1  PE array presents one partial sum this cycle.
- sel  out  2  mux select: 2 = bias, 1 = fc_reg, 0 = psum, 3 = zero.
- rd_en  out  1  psum-buffer read strobe.
- rd_addr  out  POS_CNT_W  psum-buffer read address.
- wr_en  out  1  accumulator write-back strobe.
- wr_addr  out  POS_CNT_W  write-back address.
- out_valid  out  1  write-back carries a final (last-pass) result.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start when num_pass != 0 and num_pos != 0. If either is zero: IDLE -> DONE with no rd_en or wr_en.
- In RUN, each pe_valid beat consumes one position. pos_cnt increments and wraps at num_pos-1 to 0. On wrap, pass_cnt increments.
- Beat on the last position of the last pass: RUN -> DRAIN.
- sel per beat: pass 0 -> 2 (bias; the mux sign-extends the bias and shifts it left 8). Pass > 0 -> 0 in conv mode, 1 in FC mode.
- rd_en is asserted on every beat in conv mode, including pass 0, so the read pipeline stays uniform. It is never asserted in FC mode.
- Write-back delay line of ACC_LAT stages. Each stage carries {valid, addr, last_pass}.
- DRAIN -> DONE when the delay line is empty. DONE -> IDLE after one cycle, with done = 1.
- pe_valid outside RUN is ignored.
- start while busy is ignored.
- abort in any state: clear the counters and the delay line, go to IDLE, and suppress done.
- Reset values: all outputs 0, sel = 0, state IDLE, counters 0.

## Timing
- Beat accepted at cycle t: sel, rd_en and rd_addr are registered and valid at t+1.
- wr_en, wr_addr and out_valid are valid at t+1+ACC_LAT.
- Back-to-back beats give full throughput: one write per cycle.
- busy rises at t_start+1 and falls in the cycle after done.
- done fires ACC_LAT+1 cycles after the final beat, or 1 cycle after start in the zero-size case.
- When pe_valid is low, sel holds its last value and rd_en = 0.

## Configuration
- PSUM_BIAS_INIT_EN defined: pass 0 uses sel = 2 (bias preload).
- PSUM_BIAS_INIT_EN not defined: pass 0 uses sel = 3, so the mux outputs zero and the accumulation starts from zero. All other behaviour is unchanged.

## Structure
- Shared package (Define.v): `psum_wid and `bias_wid (existing), plus the select encodings SEL_PSUM = 0, SEL_FC = 1, SEL_BIAS = 2, SEL_ZERO = 3, and the FSM state encodings.
- One natural sub-module: psum_wb_delay, the ACC_LAT-deep shift register for {valid, addr, last}, with a synchronous clear used by abort.

## Test plan
- Conv, num_pass = 2, num_pos = 3, pe_valid held high, ACC_LAT = 2:
  - sel sequence 2,2,2,0,0,0.
  - wr_addr 0,1,2,0,1,2, first write 3 cycles after the first beat.
  - out_valid only on the last 3 writes; done 3 cycles after the final beat.
- FC, num_pass = 3, num_pos = 1:
  - sel 2,1,1.
  - rd_en never asserted; out_valid on the 3rd write only.
- num_pass = 0 (or num_pos = 0), then start:
  - done 1 cycle later; no rd_en or wr_en; busy pulses for 1 cycle.
- pe_valid gapped (1,0,0,1,1) in conv mode, num_pass = 1, num_pos = 3:
  - write-backs track the beats with identical gaps.
  - addresses 0,1,2; sel held during gaps.
- abort in the cycle after the 2nd beat, with 2 writes in flight:
  - no further wr_en and no done; back in IDLE next cycle.
  - a new start runs cleanly from pos 0.
- Reset asserted mid-RUN, and start pulsed while busy:
  - reset: all outputs 0 immediately, asynchronously.
  - start while busy: no effect on the counters.

Source files
------------

// File: rtl/psum_accum_ctrl_pkg.sv
// Shared definitions for the psum/bias select sequencer: accumulator datapath
// widths, mux select codes, FSM state encoding and small select helpers.
package psum_accum_ctrl_pkg;

    localparam int PSUM_WID   = 32;
    localparam int BIAS_WID   = 16;
    localparam int BIAS_SHIFT = 8;

    localparam logic [1:0] SEL_PSUM = 2'd0;
    localparam logic [1:0] SEL_FC   = 2'd1;
    localparam logic [1:0] SEL_BIAS = 2'd2;
    localparam logic [1:0] SEL_ZERO = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Mux select for one beat: the first pass preloads, later passes feed back.
    function automatic logic [1:0] beat_sel(input logic       first_pass,
                                            input logic       fc_mode,
                                            input logic [1:0] first_sel);
        logic [1:0] s;
        if (first_pass) begin
            s = first_sel;
        end else if (fc_mode) begin
            s = SEL_FC;
        end else begin
            s = SEL_PSUM;
        end
        return s;
    endfunction

    // Bias as it appears on the psum side of the mux: sign-extended, scaled by 2^8.
    function automatic logic [PSUM_WID-1:0] align_bias(input logic [BIAS_WID-1:0] bias);
        logic [PSUM_WID-1:0] ext;
        ext = {{(PSUM_WID-BIAS_WID){bias[BIAS_WID-1]}}, bias};
        return ext << BIAS_SHIFT;
    endfunction

endpackage

// File: rtl/psum_accum_ctrl_wb.sv
// psum_wb_delay: ACC_LAT-deep shift register carrying {valid, addr, last}
// from read issue to accumulator write-back, with a synchronous flush.
module psum_wb_delay #(
    parameter int ACC_LAT = 2,
    parameter int ADDR_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_vld,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_last,
    output logic              out_vld,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);

    logic [ACC_LAT-1:0]             vld_d;
    logic [ACC_LAT-1:0]             vld_q;
    logic [ACC_LAT-1:0][ADDR_W-1:0] addr_d;
    logic [ACC_LAT-1:0][ADDR_W-1:0] addr_q;
    logic [ACC_LAT-1:0]             last_d;
    logic [ACC_LAT-1:0]             last_q;

    // Next contents: flush everything on clr, otherwise advance one stage.
    always_comb begin
        vld_d  = '0;
        addr_d = '0;
        last_d = '0;
        if (clr) begin
            vld_d  = '0;
            addr_d = '0;
            last_d = '0;
        end else begin
            vld_d[0]  = in_vld;
            addr_d[0] = in_addr;
            last_d[0] = in_last;
            for (int i = 1; i < ACC_LAT; i++) begin
                vld_d[i]  = vld_q[i-1];
                addr_d[i] = addr_q[i-1];
                last_d[i] = last_q[i-1];
            end
        end
    end

    // Stage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= '0;
            addr_q <= '0;
            last_q <= '0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
            last_q <= last_d;
        end
    end

    assign out_vld  = vld_q[ACC_LAT-1];
    assign out_addr = addr_q[ACC_LAT-1];
    assign out_last = last_q[ACC_LAT-1];

endmodule

// File: rtl/psum_accum_ctrl.sv
// Partial-sum / bias select sequencer in front of the accumulator adder.
// Build option PSUM_BIAS_INIT_EN: pass 0 preloads bias (sel=2); otherwise pass 0 starts from zero (sel=3).
module psum_accum_ctrl #(
    parameter int CH_CNT_W  = 8,
    parameter int POS_CNT_W = 12,
    parameter int ACC_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 mode,
    input  logic [CH_CNT_W-1:0]  num_pass,
    input  logic [POS_CNT_W-1:0] num_pos,
    input  logic                 pe_valid,
    output logic [1:0]           sel,
    output logic                 rd_en,
    output logic [POS_CNT_W-1:0] rd_addr,
    output logic                 wr_en,
    output logic [POS_CNT_W-1:0] wr_addr,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done
);

    import psum_accum_ctrl_pkg::*;

`ifdef PSUM_BIAS_INIT_EN
    localparam logic [1:0] FIRST_SEL = SEL_BIAS;
`else
    localparam logic [1:0] FIRST_SEL = SEL_ZERO;
`endif

    state_e                 state_d, state_q;
    logic                   mode_d, mode_q;
    logic [CH_CNT_W-1:0]    num_pass_d, num_pass_q;
    logic [POS_CNT_W-1:0]   num_pos_d, num_pos_q;
    logic [CH_CNT_W-1:0]    pass_d, pass_q;
    logic [POS_CNT_W-1:0]   pos_d, pos_q;
    logic [2:0]             drain_d, drain_q;
    logic [1:0]             sel_d, sel_q;
    logic                   rd_en_d, rd_en_q;
    logic [POS_CNT_W-1:0]   rd_addr_d, rd_addr_q;
    logic                   beat_d, beat_q;
    logic                   beat_last_d, beat_last_q;
    logic                   busy_d, busy_q;
    logic                   done_d, done_q;
    logic                   last_pos_s;
    logic                   last_pass_s;

    assign last_pos_s  = (pos_q == (num_pos_q - POS_CNT_W'(1)));
    assign last_pass_s = (pass_q == (num_pass_q - CH_CNT_W'(1)));

    // Next-state and next-output logic; abort overrides every other input.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        num_pass_d  = num_pass_q;
        num_pos_d   = num_pos_q;
        pass_d      = pass_q;
        pos_d       = pos_q;
        drain_d     = drain_q;
        sel_d       = sel_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        beat_d      = 1'b0;
        beat_last_d = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            pass_d  = '0;
            pos_d   = '0;
            drain_d = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_d     = mode;
                        num_pass_d = num_pass;
                        num_pos_d  = num_pos;
                        pass_d     = '0;
                        pos_d      = '0;
                        if ((num_pass == '0) || (num_pos == '0)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (pe_valid) begin
                        sel_d       = beat_sel(pass_q == '0, mode_q, FIRST_SEL);
                        rd_en_d     = ~mode_q;
                        rd_addr_d   = pos_q;
                        beat_d      = 1'b1;
                        beat_last_d = last_pass_s;
                        if (last_pos_s) begin
                            pos_d = '0;
                            if (last_pass_s) begin
                                // Final beat is the youngest write in flight, so a
                                // fixed countdown marks the moment it retires.
                                pass_d  = '0;
                                drain_d = 3'(ACC_LAT - 1);
                                state_d = ST_DRAIN;
                            end else begin
                                pass_d  = pass_q + CH_CNT_W'(1);
                                state_d = ST_RUN;
                            end
                        end else begin
                            pos_d = pos_q + POS_CNT_W'(1);
                        end
                    end else begin
                        sel_d = sel_q;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == 3'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        drain_d = drain_q - 3'd1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // FSM, counters, configuration and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            num_pass_q  <= '0;
            num_pos_q   <= '0;
            pass_q      <= '0;
            pos_q       <= '0;
            drain_q     <= 3'd0;
            sel_q       <= SEL_PSUM;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            beat_q      <= 1'b0;
            beat_last_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            num_pass_q  <= num_pass_d;
            num_pos_q   <= num_pos_d;
            pass_q      <= pass_d;
            pos_q       <= pos_d;
            drain_q     <= drain_d;
            sel_q       <= sel_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            beat_q      <= beat_d;
            beat_last_q <= beat_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    psum_wb_delay #(
        .ACC_LAT (ACC_LAT),
        .ADDR_W  (POS_CNT_W)
    ) u_wb_delay (
        .clk      (clk),
        .rst      (rst),
        .clr      (abort),
        .in_vld   (beat_q),
        .in_addr  (rd_addr_q),
        .in_last  (beat_last_q),
        .out_vld  (wr_en),
        .out_addr (wr_addr),
        .out_last (out_valid)
    );

    assign sel     = sel_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Self-checking bench for psum_accum_ctrl: table of jobs, hand-written corner
// sequences and randomized jobs checked cycle by cycle against a beat-level model.
module tb_psum_accum_ctrl;

    localparam int L    = 2;
    localparam int MAXC = 200;
`ifdef PSUM_BIAS_INIT_EN
    localparam logic [1:0] FIRST_SEL = 2'd2;
`else
    localparam logic [1:0] FIRST_SEL = 2'd3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, mode, pe_valid;
    logic [7:0]  num_pass;
    logic [11:0] num_pos;
    logic [1:0]  sel;
    logic        rd_en, wr_en, out_valid, busy, done;
    logic [11:0] rd_addr, wr_addr;

    int n_chk = 0;
    int n_fail = 0;
    bit pv [MAXC];
    logic [1:0] exp_sel_g = 2'd0;
    int got_wr, got_fin, got_rd, got_done;
    int wr_cyc [$];

    typedef struct {
        bit m; int np; int npos; int gap; int ab;
        int x_wr; int x_fin; int x_rd; int x_done;
    } vec_t;

    psum_accum_ctrl #(.CH_CNT_W(8), .POS_CNT_W(12), .ACC_LAT(L)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .num_pass(num_pass), .num_pos(num_pos), .pe_valid(pe_valid),
        .sel(sel), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en),
        .wr_addr(wr_addr), .out_valid(out_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time expired, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, c, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sel"},     0, 32'(sel), 32'd0);
        check({tag, "_rd_en"},   0, 32'(rd_en), 32'd0);
        check({tag, "_rd_addr"}, 0, 32'(rd_addr), 32'd0);
        check({tag, "_wr_en"},   0, 32'(wr_en), 32'd0);
        check({tag, "_wr_addr"}, 0, 32'(wr_addr), 32'd0);
        check({tag, "_out_vld"}, 0, 32'(out_valid), 32'd0);
        check({tag, "_busy"},    0, 32'(busy), 32'd0);
        check({tag, "_done"},    0, 32'(done), 32'd0);
    endtask

    task automatic gen_pv(input int gap);
        for (int i = 0; i < MAXC; i++) pv[i] = ($urandom_range(99) >= gap);
    endtask

    // Beat k (k-th accepted pe_valid) lands on position k%npos of pass k/npos;
    // its read shows one cycle later and its write-back L cycles after that.
    task automatic run_job(input bit m, input int np, input int npos, input int ab);
        bit e_rd [MAXC]; bit e_wr [MAXC]; bit e_ov [MAXC]; bit e_ss [MAXC];
        bit e_busy [MAXC]; bit e_done [MAXC];
        int e_ra [MAXC]; int e_wa [MAXC];
        logic [1:0] e_sel [MAXC];
        logic [1:0] cur;
        int total, k, cf, dc, bend, ncyc;
        for (int c = 0; c < MAXC; c++) begin
            e_rd[c] = 0; e_wr[c] = 0; e_ov[c] = 0; e_ss[c] = 0;
            e_busy[c] = 0; e_done[c] = 0; e_ra[c] = 0; e_wa[c] = 0; e_sel[c] = 2'd0;
        end
        total = np * npos; k = 0; cf = -1;
        for (int c = 1; c < MAXC - L - 8; c++) begin
            if ((ab < 0 || c < ab) && k < total && pv[c]) begin
                e_rd[c+1] = !m; e_ra[c+1] = k % npos; e_ss[c+1] = 1;
                e_sel[c+1] = (k / npos == 0) ? FIRST_SEL : (m ? 2'd1 : 2'd0);
                if (ab < 0 || c + 1 + L <= ab) begin
                    e_wr[c+1+L] = 1; e_wa[c+1+L] = k % npos; e_ov[c+1+L] = (k / npos == np - 1);
                end
                k++;
                if (k == total) cf = c;
            end
        end
        if (total == 0) dc = 1;
        else if (cf >= 0) dc = cf + 1 + L;
        else dc = -1;
        if (ab < 0 && dc < 0) begin
            n_chk++; n_fail++;
            $display("FAIL model_budget: job not finished in %0d cycles, expected completion", MAXC);
            return;
        end
        bend = (ab >= 0 && (dc < 0 || dc > ab)) ? ab : dc;
        for (int c = 1; c <= bend; c++) e_busy[c] = 1;
        if (dc >= 0 && dc <= bend) e_done[dc] = 1;
        ncyc = ((ab > bend) ? ab : bend) + 3;
        cur = exp_sel_g;
        for (int c = 0; c <= ncyc; c++) begin
            if (e_ss[c]) cur = e_sel[c];
            e_sel[c] = cur;
        end
        exp_sel_g = cur;
        got_wr = 0; got_fin = 0; got_rd = 0; got_done = 0;
        wr_cyc.delete();
        for (int c = 0; c <= ncyc; c++) begin
            abort = (c == ab);
            pe_valid = pv[c];
            if (c == 0) begin
                start = 1'b1; mode = m; num_pass = 8'(np); num_pos = 12'(npos);
            end else if (c <= bend && $urandom_range(9) == 0) begin
                start = 1'b1; mode = 1'($urandom_range(1));
                num_pass = 8'($urandom_range(255)); num_pos = 12'($urandom_range(4095));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            check("busy", c, 32'(busy), 32'(e_busy[c]));
            check("done", c, 32'(done), 32'(e_done[c]));
            check("rd_en", c, 32'(rd_en), 32'(e_rd[c]));
            check("wr_en", c, 32'(wr_en), 32'(e_wr[c]));
            check("out_valid", c, 32'(out_valid), 32'(e_wr[c] & e_ov[c]));
            check("sel", c, 32'(sel), 32'(e_sel[c]));
            if (e_rd[c]) check("rd_addr", c, 32'(rd_addr), e_ra[c]);
            if (e_wr[c]) check("wr_addr", c, 32'(wr_addr), e_wa[c]);
            if (wr_en) begin got_wr++; wr_cyc.push_back(c); end
            if (wr_en && out_valid) got_fin++;
            if (rd_en) got_rd++;
            if (done) got_done++;
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; pe_valid = 1'b0;
    endtask

    initial begin
        vec_t tbl [8];
        int exp_wc [3];
        tbl[0] = '{1'b0, 2, 3, 0,  -1, 6,  3, 6,  1};
        tbl[1] = '{1'b1, 3, 1, 0,  -1, 3,  1, 0,  1};
        tbl[2] = '{1'b0, 0, 5, 0,  -1, 0,  0, 0,  1};
        tbl[3] = '{1'b1, 4, 0, 0,  -1, 0,  0, 0,  1};
        tbl[4] = '{1'b0, 1, 3, 0,   3, 0,  0, 2,  0};
        tbl[5] = '{1'b0, 1, 3, 0,  -1, 3,  3, 3,  1};
        tbl[6] = '{1'b0, 3, 4, 30, -1, 12, 4, 12, 1};
        tbl[7] = '{1'b1, 2, 5, 50, -1, 10, 5, 0,  1};

        rst = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; pe_valid = 1'b0;
        num_pass = 8'd0; num_pos = 12'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            gen_pv(tbl[i].gap);
            run_job(tbl[i].m, tbl[i].np, tbl[i].npos, tbl[i].ab);
            check("tbl_writes", i, got_wr, tbl[i].x_wr);
            check("tbl_final", i, got_fin, tbl[i].x_fin);
            check("tbl_reads", i, got_rd, tbl[i].x_rd);
            check("tbl_done", i, got_done, tbl[i].x_done);
        end

        // Gapped beats 1,0,0,1,1: write-backs keep the same spacing.
        for (int i = 0; i < MAXC; i++) pv[i] = 1'b0;
        pv[1] = 1'b1; pv[4] = 1'b1; pv[5] = 1'b1;
        run_job(1'b0, 1, 3, -1);
        exp_wc[0] = 1 + 1 + L; exp_wc[1] = 4 + 1 + L; exp_wc[2] = 5 + 1 + L;
        check("gap_wr_count", 0, wr_cyc.size(), 3);
        for (int i = 0; i < 3 && i < wr_cyc.size(); i++) check("gap_wr_cycle", i, wr_cyc[i], exp_wc[i]);

        // Reset asserted mid-RUN, with a start pulse while busy just before.
        start = 1'b1; mode = 1'b0; num_pass = 8'd2; num_pos = 12'd4;
        @(posedge clk); #1;
        start = 1'b0; pe_valid = 1'b1;
        repeat (2) @(posedge clk); #1;
        start = 1'b1; num_pass = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("midrun_busy", 0, 32'(busy), 32'd1);
        check("midrun_rd_en", 0, 32'(rd_en), 32'd1);
        #2 rst = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst = 1'b1; pe_valid = 1'b0;
        @(posedge clk); #1;
        exp_sel_g = 2'd0;
        gen_pv(20);
        run_job(1'b0, 2, 3, -1);
        check("post_rst_writes", 0, got_wr, 6);

        for (int j = 0; j < 20; j++) begin
            bit rm;
            int rnp, rnpos, rab;
            rm = 1'($urandom_range(1));
            rnp = $urandom_range(4);
            rnpos = $urandom_range(6);
            rab = ($urandom_range(3) == 0) ? $urandom_range(20, 1) : -1;
            gen_pv($urandom_range(60));
            run_job(rm, rnp, rnpos, rab);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
